// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx: UART transmitter with a small TX FIFO for the APB_UART datapath.
//
// Frame: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 even-parity bit
// (XOR of the data bits), then the stop phase (1). Each serial bit lasts
// exactly 16 baud_en_16x pulses.
//
// Build option:
//   UART_TX_TWO_STOP_EN  defined   -> stop phase is two bits (32 ticks)
//                        undefined -> stop phase is one bit (16 ticks)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   baud_en_16x  one-clk pulse at 16x the baud rate
//   tx_data      word to queue (sampled only when a push occurs)
//   tx_valid     push request
//   tx_ready     FIFO can accept; push happens on tx_valid && tx_ready
//   tx           serial line, idle high, registered
//   tx_busy      frame in progress (state other than IDLE), registered
//   tx_done      one-clk pulse when the stop phase completes, registered
//   fifo_level   current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          baud_en_16x,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W     = PTR_W + 1;
    localparam int unsigned OS_W      = 4;
    localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
`ifdef UART_TX_TWO_STOP_EN
    localparam int unsigned STOP_BITS = 2;
`else
    localparam int unsigned STOP_BITS = 1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        PARITY_BIT,
        STOP_BIT
    } state_e;

    // Registered state
    state_e                  state_q,    state_d;
    logic [DATA_WIDTH-1:0]   shift_q,    shift_d;
    logic                    parity_q,   parity_d;
    logic [OS_W-1:0]         os_cnt_q,   os_cnt_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [PTR_W-1:0]        wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]        level_q,    level_d;
    logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_mem_d [FIFO_DEPTH];
    logic                    tx_q,       tx_d;
    logic                    tx_busy_q,  tx_busy_d;
    logic                    tx_done_q,  tx_done_d;

    // Combinational helpers
    logic                    push;
    logic                    pop;
    logic                    load;
    logic                    bit_end;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   head;

    // Next-state, FIFO and output computation
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_mem_d = fifo_mem_q;
        tx_done_d  = 1'b0;
        load       = 1'b0;
        bit_end    = 1'b0;

        // Space is judged on the registered level only: a same-cycle pop
        // never makes room for a push.
        push       = tx_valid && (level_q != LVL_W'(FIFO_DEPTH));
        fifo_empty = (level_q == '0);
        head       = fifo_mem_q[rd_ptr_q];

        // Oversample counter: 16 baud pulses per serial bit
        if ((state_q != IDLE) && baud_en_16x) begin
            if (os_cnt_q == OS_W'(15)) begin
                os_cnt_d = '0;
                bit_end  = 1'b1;
            end else begin
                os_cnt_d = os_cnt_q + OS_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    state_d = DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = PARITY_BIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            PARITY_BIT: begin
                if (bit_end) begin
                    state_d = STOP_BIT;
                end
            end
            STOP_BIT: begin
                // bit_cnt is reused to count stop bits
                if (bit_end) begin
                    if (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1)) begin
                        tx_done_d = 1'b1;
                        bit_cnt_d = '0;
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pop the head word into the shift register and start a new frame
        pop = load;
        if (load) begin
            shift_d   = head;
            parity_d  = ^head;
            os_cnt_d  = '0;
            bit_cnt_d = '0;
            state_d   = START_BIT;
        end

        if (push) begin
            fifo_mem_d[wr_ptr_q] = tx_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);

        // Line level follows the current state, so tx trails state by one clk
        case (state_q)
            START_BIT:  tx_d = 1'b0;
            DATA_BITS:  tx_d = shift_q[bit_cnt_q];
            PARITY_BIT: tx_d = parity_q;
            default:    tx_d = 1'b1;
        endcase

        tx_busy_d = (state_d != IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            fifo_mem_q <= '{default: '0};
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            fifo_mem_q <= fifo_mem_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx_ready   = (level_q != LVL_W'(FIFO_DEPTH));
    assign fifo_level = level_q;
    assign tx         = tx_q;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter for the APB_UART datapath. It is the counterpart of the team's oversampling receiver and uses the same frame format: 1 start bit, DATA_WIDTH data bits LSB first, 1 even-parity bit (parity bit = XOR of data bits), and 1 stop bit. Bit timing comes from the shared 16x baud enable. Writes from the APB register side are buffered in a small FIFO with a valid/ready handshake.

Parameters:
DATA_WIDTH, 8, data bits per frame
FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
baud_en_16x  input  1  one-clk pulse at 16x baud rate
tx_data  input  DATA_WIDTH  byte to queue
tx_valid  input  1  push request
tx_ready  output  1  FIFO can accept; push occurs when tx_valid && tx_ready
tx  output  1  serial line, idle high, registered
tx_busy  output  1  frame in progress (any state other than IDLE)
tx_done  output  1  one-clk pulse when stop bit completes
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: tx=1, tx_busy=0, tx_done=0, tx_ready=1, fifo_level=0. State=IDLE. FIFO pointers, shift register and counters are cleared.
- Reset mid-frame: the frame is aborted, tx returns to 1 immediately, and queued data is discarded.
- FIFO:
  - tx_ready = (fifo_level != FIFO_DEPTH), registered-state based.
  - A pop in the same cycle does not free space for a push in that cycle.
  - A simultaneous push and pop when not full leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT.
  - IDLE: tx=1. If the FIFO is non-empty: pop into the shift register, compute parity = ^data, clear oversample_cnt and bit_cnt, go to START_BIT.
  - Bit timing: each serial bit lasts exactly 16 baud_en_16x pulses. oversample_cnt increments only on baud_en_16x. On the pulse where cnt==15, cnt wraps to 0 and the bit ends.
  - START_BIT: tx=0 for 16 ticks, then DATA_BITS.
  - DATA_BITS: tx = shift[bit_cnt], bit_cnt 0..DATA_WIDTH-1. After bit DATA_WIDTH-1 ends, go to PARITY_BIT.
  - PARITY_BIT: tx = parity for 16 ticks, then STOP_BIT.
  - STOP_BIT: tx=1 for 16 ticks. At the end, pulse tx_done for 1 clk.
    - If the FIFO is non-empty, pop and go directly to START_BIT (back-to-back frames, no idle bits).
    - Otherwise go to IDLE.
- Latency: push at clk N into an empty FIFO while IDLE gives pop at N+1, and tx falls at N+2.
- tx is updated by register from the state and shift register; no combinational path from the inputs to tx.
- tx_data is sampled only at push. The FIFO contents are stable while the word is being serialized.
- baud_en_16x held high continuously is legal; bits are then 16 clks.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: STOP_BIT lasts 32 ticks (two stop bits). tx_done pulses at the end of the second stop bit.
- Undefined: one stop bit of 16 ticks.
- The frame is otherwise identical either way.

Test Plan:
- Send 0xA5, baud_en_16x every 4 clks. tx sequence, each bit 16 ticks: 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1. tx_done pulses once; tx_busy drops the same cycle the state reaches IDLE.
- Send 0x07. Parity bit = 1. Total frame = 11 bits × 16 ticks = 176 baud pulses from the falling edge of tx to tx_done.
- Loopback with the team's receiver: push 0x3C, 0xFF, 0x00 back-to-back. Receiver reports rx_ready with the same three values, rx_error never asserts, and there is no idle gap between frames.
- FIFO full: push 6 bytes on consecutive clks from reset. Byte 0 is popped, 4 are queued (fifo_level=4), tx_ready=0, and byte 5 is not accepted. The remaining 5 bytes transmit in order.
- Reset mid-frame: assert rst_n=0 during DATA_BITS with 3 bytes queued. tx=1, tx_busy=0, fifo_level=0 immediately. After release, no frame is sent until a new push.
- With UART_TX_TWO_STOP_EN defined: the stop phase lasts 32 ticks, and the next start bit begins exactly 32 ticks after the parity bit ends.
